// File: rtl/tli4970_pkg.sv
// Shared constants for the TLI4970 sensor array: frame bit layout, default
// zero-current offset and the frame engine state encoding.
package tli4970_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int STATUS_BIT     = 15;
  localparam int PARITY_BIT     = 14;
  localparam int OCD_BIT        = 13;
  localparam int DATA_MSB       = 12;
  localparam int DEFAULT_OFFSET = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SHIFT,
    ST_DESELECT,
    ST_STORE
  } rx_state_e;

endpackage

// File: rtl/tli4970_array_if.sv
// SPI pin bundle for the sensor array: one shared SCK, per-channel CS and MISO.
interface tli4970_array_if #(
  parameter int NUM_CHANNELS = 4
);

  logic [NUM_CHANNELS-1:0] spi_miso;
  logic [NUM_CHANNELS-1:0] spi_cs;
  logic                    spi_clk;

  modport master (input spi_miso, output spi_cs, output spi_clk);
  modport slave  (output spi_miso, input spi_cs, input spi_clk);

endinterface

// File: rtl/tli4970_array_spi_frame_rx.sv
// Single-frame SPI read engine: SELECT, 16 SCK periods, DESELECT, STORE.
// Parity acceptance is compiled in with TLI4970_PARITY_EN.
module spi_frame_rx
  import tli4970_pkg::*;
#(
  parameter int SPI_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                miso_i,
  output logic                busy_o,
  output logic                cs_en_o,
  output logic                sck_o,
  output logic                done_o,
  output logic                status_o,
  output logic                ocd_o,
  output logic [DATA_MSB:0]   data_o,
  output logic                parity_ok_o
);

  localparam int DIV_W  = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int HALF_W = $clog2(2 * FRAME_BITS);

  rx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [HALF_W-1:0]     half_q, half_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic                  div_end;

  assign div_end = (div_q == DIV_W'(SPI_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      half_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
    end
    sr_q <= sr_d;
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_end ? '0 : div_q + 1'b1;
    half_d  = half_q;
    sr_d    = sr_q;
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (start_i) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (div_end) begin
          state_d = ST_SHIFT;
          half_d  = '0;
        end
      end
      ST_SHIFT: begin
        // odd half-periods are SCK low; capture on the first low cycle
        if (half_q[0] && div_q == '0) sr_d = {sr_q[FRAME_BITS-2:0], miso_i};
        if (div_end) begin
          half_d = half_q + 1'b1;
          if (half_q == HALF_W'(2 * FRAME_BITS - 1)) state_d = ST_DESELECT;
        end
      end
      ST_DESELECT: begin
        if (div_end) state_d = ST_STORE;
      end
      ST_STORE: begin
        div_d   = '0;
        state_d = start_i ? ST_SELECT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign cs_en_o  = (state_q == ST_SELECT) || (state_q == ST_SHIFT);
  assign sck_o    = (state_q == ST_SHIFT) && !half_q[0];
  assign done_o   = (state_q == ST_STORE);
  assign status_o = sr_q[STATUS_BIT];
  assign ocd_o    = sr_q[OCD_BIT];
  assign data_o   = sr_q[DATA_MSB:0];

`ifdef TLI4970_PARITY_EN
  assign parity_ok_o = ~^sr_q;
`else
  assign parity_ok_o = 1'b1;
`endif

endmodule

// File: rtl/tli4970_array.sv
// Polls NUM_CHANNELS TLI4970 sensors each update tick and decodes their frames.
// Optional parity checking: define TLI4970_PARITY_EN.
module tli4970_array
  import tli4970_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CLOCK_FREQ   = 16_000_000,
  parameter int SPI_DIV      = 4,
  parameter int UPDATE_FREQ  = 1000,
  parameter int OFFSET       = DEFAULT_OFFSET
) (
  input  logic                      clk,
  input  logic                      reset,
  tli4970_array_if.master           spi,
  output logic [16*NUM_CHANNELS-1:0] current,
  output logic [NUM_CHANNELS-1:0]   current_valid,
  output logic [NUM_CHANNELS-1:0]   ocd,
  output logic [NUM_CHANNELS-1:0]   status_seen,
  output logic [NUM_CHANNELS-1:0]   parity_err,
  output logic                      overrun,
  input  logic                      err_clear
);

  localparam int PERIOD = CLOCK_FREQ / UPDATE_FREQ;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  function automatic logic signed [15:0] raw_to_current(input logic [DATA_MSB:0] raw);
    logic signed [15:0] r;
    r = $signed({3'b000, raw});
    return r - $signed(16'(OFFSET));
  endfunction

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [16*NUM_CHANNELS-1:0]  cur_q, cur_d;
  logic [NUM_CHANNELS-1:0]     vld_q, vld_d, ocd_q, ocd_d;
  logic [NUM_CHANNELS-1:0]     stat_q, stat_d, perr_q, perr_d;
  logic                        ovr_q, ovr_d;
  logic                        tick, start, busy, cs_en, sck, done;
  logic                        f_status, f_ocd, f_par_ok;
  logic [DATA_MSB:0]           f_data;

  spi_frame_rx #(.SPI_DIV(SPI_DIV)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .miso_i     (spi.spi_miso[ch_q]),
    .busy_o     (busy),
    .cs_en_o    (cs_en),
    .sck_o      (sck),
    .done_o     (done),
    .status_o   (f_status),
    .ocd_o      (f_ocd),
    .data_o     (f_data),
    .parity_ok_o(f_par_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      ch_q   <= '0;
      cur_q  <= '0;
      vld_q  <= '0;
      ocd_q  <= '0;
      stat_q <= '0;
      perr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ch_q   <= ch_d;
      cur_q  <= cur_d;
      vld_q  <= vld_d;
      ocd_q  <= ocd_d;
      stat_q <= stat_d;
      perr_q <= perr_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    tick  = (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    start = 1'b0;
    ch_d  = ch_q;
    // STORE of a non-final channel chains straight into the next SELECT
    if (tick && !busy) begin
      start = 1'b1;
      ch_d  = '0;
    end else if (done && ch_q != LAST_CH) begin
      start = 1'b1;
      ch_d  = ch_q + 1'b1;
    end

    cur_d  = cur_q;
    ocd_d  = ocd_q;
    vld_d  = '0;
    stat_d = stat_q & ~{NUM_CHANNELS{err_clear}};
    perr_d = perr_q & ~{NUM_CHANNELS{err_clear}};
    ovr_d  = (ovr_q & ~err_clear) | (tick & busy);
    if (done) begin
      if (!f_par_ok) begin
        perr_d[ch_q] = 1'b1;
      end else if (f_status) begin
        stat_d[ch_q] = 1'b1;
      end else begin
        cur_d[{ch_q, 4'b0000} +: 16] = raw_to_current(f_data);
        ocd_d[ch_q] = f_ocd;
        vld_d[ch_q] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      spi.spi_cs[k] = !(cs_en && ch_q == CH_W'(k));
    end
  end

  assign spi.spi_clk    = sck;
  assign current        = cur_q;
  assign current_valid  = vld_q;
  assign ocd            = ocd_q;
  assign status_seen    = stat_q;
  assign parity_err     = perr_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_tli4970_array.sv
// Directed bench for tli4970_array: two channels, H=2, sensor models driving MISO.
// Build with TLI4970_PARITY_EN to exercise the parity-checking variant.
module tb_tli4970_array;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_clear = 1'b0;
  always #5 clk = ~clk;

  tli4970_array_if #(.NUM_CHANNELS(N)) bus ();
  tli4970_array_if #(.NUM_CHANNELS(N)) bus_o ();

  logic [16*N-1:0] current, current_o;
  logic [N-1:0]    cv, ocd, stat, perr, cv_o, ocd_o, stat_o, perr_o;
  logic            ovr, ovr_o;

  tli4970_array #(.NUM_CHANNELS(N), .CLOCK_FREQ(200_000), .SPI_DIV(2),
                  .UPDATE_FREQ(1000), .OFFSET(4096)) u_dut (
    .clk(clk), .reset(reset), .spi(bus), .current(current), .current_valid(cv),
    .ocd(ocd), .status_seen(stat), .parity_err(perr), .overrun(ovr), .err_clear(err_clear));

  // period of 100 cycles is shorter than the 138-cycle poll
  tli4970_array #(.NUM_CHANNELS(N), .CLOCK_FREQ(100_000), .SPI_DIV(2),
                  .UPDATE_FREQ(1000), .OFFSET(4096)) u_ovr (
    .clk(clk), .reset(reset), .spi(bus_o), .current(current_o), .current_valid(cv_o),
    .ocd(ocd_o), .status_seen(stat_o), .parity_err(perr_o), .overrun(ovr_o), .err_clear(err_clear));

  assign bus_o.spi_miso = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int viol = 0;
  int idle_run = 0;
  int run [N];
  int last_len [N];
  logic [15:0] word [N];
  int sbit = 0;
  logic sck_prev = 1'b0;

  always @(posedge clk) cyc++;

  // sensor model: present the next bit on each SCK rise
  always @(negedge clk) begin
    if (&bus.spi_cs) sbit = 0;
    else if (bus.spi_clk && !sck_prev) begin
      for (int k = 0; k < N; k++) if (!bus.spi_cs[k]) bus.spi_miso[k] = word[k][15-sbit];
      sbit = sbit + 1;
    end
    sck_prev = bus.spi_clk;
  end

  always @(negedge clk) begin
    if (cyc > 2) begin
      if ($countones(~bus.spi_cs) > 1 || (bus.spi_clk && (&bus.spi_cs))) viol++;
      if ($countones(~bus_o.spi_cs) > 1 || (bus_o.spi_clk && (&bus_o.spi_cs))) viol++;
    end
    idle_run = (&bus.spi_cs) ? idle_run + 1 : 0;
    for (int k = 0; k < N; k++) begin
      if (!bus.spi_cs[k]) run[k]++;
      else if (run[k] != 0) begin last_len[k] = run[k]; run[k] = 0; end
    end
  end

  function automatic logic [15:0] mk(input logic [15:0] w);
`ifdef TLI4970_PARITY_EN
    return (^w) ? (w | 16'h4000) : w;
`else
    return w;
`endif
  endfunction

  task automatic wait_pulse(input int ch, input bit use_o, input int budget, output bit got, output int at);
    got = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((use_o ? cv_o[ch] : cv[ch]) === 1'b1) begin got = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic wait_gap(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (idle_run >= 10) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    word[0] = mk(16'h1000);
    word[1] = mk(16'h1FFF);
    repeat (3) @(negedge clk);
    total++; if (bus.spi_cs !== 2'b11) begin bad++; $display("FAIL rst_cs got=%b want=11", bus.spi_cs); end
    total++; if (bus.spi_clk !== 1'b0) begin bad++; $display("FAIL rst_sck got=%b want=0", bus.spi_clk); end
    total++; if (current !== 32'h0) begin bad++; $display("FAIL rst_current got=%h want=0", current); end
    total++; if ({cv, ocd, stat, perr, ovr} !== 9'h0) begin bad++; $display("FAIL rst_flags got=%h want=0", {cv, ocd, stat, perr, ovr}); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit g0, g1;
    int a0, a1;
    wait_pulse(0, 1'b0, 400, g0, a0);
    total++; if (!g0) begin bad++; $display("FAIL basic_vld0 timeout got=0 want=1"); end
    total++; if (current[15:0] !== 16'h0000) begin bad++; $display("FAIL basic_cur0 got=%h want=0000", current[15:0]); end
    total++; if (last_len[0] !== 66) begin bad++; $display("FAIL basic_cslen0 got=%0d want=66", last_len[0]); end
    wait_pulse(1, 1'b0, 100, g1, a1);
    total++; if (!g1) begin bad++; $display("FAIL basic_vld1 timeout got=0 want=1"); end
    total++; if (current[31:16] !== 16'h0FFF) begin bad++; $display("FAIL basic_cur1 got=%h want=0fff", current[31:16]); end
    total++; if (a1 - a0 !== 69) begin bad++; $display("FAIL basic_spacing got=%0d want=69", a1 - a0); end
    total++; if (last_len[1] !== 66) begin bad++; $display("FAIL basic_cslen1 got=%0d want=66", last_len[1]); end
  endtask

  task automatic test_min_ocd();
    bit ok, g;
    int a;
    wait_gap(ok);
    total++; if (!ok) begin bad++; $display("FAIL ocd_gap timeout got=0 want=1"); end
    word[0] = mk(16'h0000);
    wait_pulse(0, 1'b0, 300, g, a);
    total++; if (current[15:0] !== 16'hF000 || !g) begin bad++; $display("FAIL min_cur0 got=%h want=f000", current[15:0]); end
    total++; if (ocd[0] !== 1'b0) begin bad++; $display("FAIL min_ocd0 got=%b want=0", ocd[0]); end
    wait_gap(ok);
    word[0] = mk(16'h2000);
    wait_pulse(0, 1'b0, 300, g, a);
    total++; if (current[15:0] !== 16'hF000 || !g) begin bad++; $display("FAIL ocd_cur0 got=%h want=f000", current[15:0]); end
    total++; if (ocd[0] !== 1'b1) begin bad++; $display("FAIL ocd_flag0 got=%b want=1", ocd[0]); end
  endtask

  task automatic test_status();
    bit ok, g;
    int a, pulses;
    wait_gap(ok);
    word[1] = mk(16'h8123);
    wait_pulse(0, 1'b0, 300, g, a);
    total++; if (!g) begin bad++; $display("FAIL stat_vld0 timeout got=0 want=1"); end
    pulses = 0;
    repeat (80) begin @(negedge clk); if (cv[1] === 1'b1) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL stat_pulse got=%0d want=0", pulses); end
    total++; if (stat !== 2'b10) begin bad++; $display("FAIL stat_seen got=%b want=10", stat); end
    total++; if (current[31:16] !== 16'h0FFF) begin bad++; $display("FAIL stat_cur1 got=%h want=0fff", current[31:16]); end
    wait_gap(ok);
    word[1] = mk(16'h1FFF);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    total++; if (stat !== 2'b00) begin bad++; $display("FAIL stat_clear got=%b want=00", stat); end
  endtask

  task automatic test_parity();
    bit ok, g;
    int a, pulses;
    wait_gap(ok);
    word[0] = 16'h4001;
    wait_pulse(0, 1'b0, 300, g, a);
    total++; if (current[15:0] !== 16'hF001 || !g) begin bad++; $display("FAIL par_even_cur got=%h want=f001", current[15:0]); end
    wait_gap(ok);
    word[0] = 16'h0003;
    wait_pulse(0, 1'b0, 300, g, a);
    total++; if (current[15:0] !== 16'hF003 || !g) begin bad++; $display("FAIL par_even2_cur got=%h want=f003", current[15:0]); end
    wait_gap(ok);
    word[0] = 16'h0001;
`ifdef TLI4970_PARITY_EN
    pulses = 0;
    repeat (250) begin @(negedge clk); if (cv[0] === 1'b1) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL par_odd_pulse got=%0d want=0", pulses); end
    total++; if (perr[0] !== 1'b1) begin bad++; $display("FAIL par_err got=%b want=1", perr[0]); end
    total++; if (current[15:0] !== 16'hF003) begin bad++; $display("FAIL par_hold got=%h want=f003", current[15:0]); end
`else
    pulses = 0;
    wait_pulse(0, 1'b0, 300, g, a);
    total++; if (current[15:0] !== 16'hF001 || !g) begin bad++; $display("FAIL nopar_cur got=%h want=f001", current[15:0]); end
    total++; if (perr !== 2'b00) begin bad++; $display("FAIL nopar_err got=%b want=00", perr); end
`endif
  endtask

  task automatic test_overrun();
    bit g0, g1;
    int a0, a1;
    wait_pulse(0, 1'b1, 400, g0, a0);
    wait_pulse(0, 1'b1, 400, g1, a1);
    total++; if (!(g0 && g1) || a1 - a0 !== 200) begin bad++; $display("FAIL ovr_spacing got=%0d want=200", a1 - a0); end
    total++; if (ovr_o !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", ovr_o); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL ovr_main got=%b want=0", ovr); end
  endtask

  task automatic test_reset_mid();
    bit hit, g;
    int a;
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.spi_clk === 1'b1 && bus.spi_cs[0] === 1'b0) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_shift timeout got=0 want=1"); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.spi_cs !== 2'b11 || bus.spi_clk !== 1'b0) begin bad++; $display("FAIL mid_bus got=%b%b want=110", bus.spi_cs, bus.spi_clk); end
    total++; if (current !== 32'h0) begin bad++; $display("FAIL mid_current got=%h want=0", current); end
    total++; if ({cv, ocd, stat, perr} !== 8'h0) begin bad++; $display("FAIL mid_flags got=%h want=0", {cv, ocd, stat, perr}); end
    word[0] = mk(16'h1000);
    @(negedge clk);
    reset = 1'b0;
    wait_pulse(0, 1'b0, 400, g, a);
    total++; if (current[15:0] !== 16'h0000 || !g) begin bad++; $display("FAIL mid_recover got=%h want=0000", current[15:0]); end
  endtask

  task automatic test_bus_rules();
    total++; if (viol !== 0) begin bad++; $display("FAIL bus_rules got=%0d want=0", viol); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin run[k] = 0; last_len[k] = 0; end
    test_reset();
    test_basic();
    test_min_ocd();
    test_status();
    test_parity();
    test_overrun();
    test_reset_mid();
    test_bus_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tli4970_array.md
# tli4970_array

Multi-channel successor to the single-sensor TLI4970 reader. Polls `NUM_CHANNELS` TLI4970 current sensors over one shared SPI clock with per-channel chip selects at a fixed update rate. Decodes each 16-bit frame into a signed, offset-corrected current, an over-current flag and sticky error flags. Sits between the sensor pins and the motor-control/telemetry logic of the iceboard.

## Interface
Parameters:
- `NUM_CHANNELS`, 4: number of sensors, 1..16.
- `CLOCK_FREQ`, 16_000_000: `clk` frequency in Hz.
- `SPI_DIV`, 4: `clk` cycles per SCK half-period (H), ≥1.
- `UPDATE_FREQ`, 1000: poll rate in Hz; PERIOD = CLOCK_FREQ/UPDATE_FREQ cycles.
- `OFFSET`, 4096: zero-current raw code.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `spi_miso`  in  NUM_CHANNELS  per-sensor data; bit k belongs to channel k.
- `spi_cs`  out  NUM_CHANNELS  active-low chip selects.
- `spi_clk`  out  1  shared SCK, idles low.
- `current`  out  16*NUM_CHANNELS  signed current; channel k at [16k+15:16k].
- `current_valid`  out  NUM_CHANNELS  1-cycle pulse when channel k's `current` updates.
- `ocd`  out  NUM_CHANNELS  over-current bit from the latest valid value frame.
- `status_seen`  out  NUM_CHANNELS  sticky: a status frame (bit15=1) was received.
- `parity_err`  out  NUM_CHANNELS  sticky: parity failure.
- `overrun`  out  1  sticky: a tick arrived while a poll was still running.
- `err_clear`  in  1  clears `status_seen`, `parity_err` and `overrun`.

## Operation
- Free-running tick counter 0..PERIOD-1; the tick fires at PERIOD-1. The first tick fires PERIOD cycles after `reset` deasserts.
- A tick in IDLE starts a poll of channels 0..NUM_CHANNELS-1 in order.
- A tick while busy sets `overrun` and is dropped; the poll is not restarted.
- Per-channel FSM: IDLE → SELECT → SHIFT → DESELECT → STORE, then the next channel's SELECT or IDLE.
  - SELECT: `spi_cs[k]`=0, SCK low, H cycles.
  - SHIFT: 16 bits, MSB first. Each bit is SCK high for H cycles, then low for H cycles. `spi_miso[k]` is sampled on the cycle SCK falls.
  - DESELECT: all CS high, SCK low, H cycles.
  - STORE: 1 cycle.
- Frame decode at STORE:
  - bit15=0 (value frame): raw = bits[12:0] as unsigned. `current[k]` = {3'b0,raw} − OFFSET as 16-bit signed (−4096..4095 with defaults). `ocd[k]` = bit13. `current_valid[k]` pulses.
  - bit15=1 (status frame): `current[k]` and `ocd[k]` are unchanged, no valid pulse, `status_seen[k]` is set.
- Sticky flags: if set and `err_clear` occur in the same cycle, set wins.
- Only one CS is ever low at a time. SCK toggles only while some CS is low.

## Timing
- Per-channel frame = 34H+1 cycles, where CS is low for 33H. Full poll = NUM_CHANNELS*(34H+1) cycles.
- `current_valid[k]` is asserted in the cycle after STORE, coincident with the new `current[k]`.
- Channel k's valid pulse follows the tick by (k+1)*(34H+1) cycles.
- PERIOD ≤ NUM_CHANNELS*(34H+1) is legal. Every tick that lands mid-poll is dropped and sets `overrun`.
- Reset values: `spi_cs` all 1, `spi_clk` 0, `current` 0, `current_valid` 0, `ocd` 0, all sticky flags 0, FSM IDLE, tick counter 0.
- Reset mid-frame: CS deasserts and SCK goes low on the next edge. The partial frame is discarded.

## Configuration
- `TLI4970_PARITY_EN` defined: a frame is accepted only if the count of ones over all 16 bits (bit14 is the parity bit) is even. On failure the frame is discarded: no `current`/`ocd`/`status_seen` update, no valid pulse, and `parity_err[k]` is set.
- Undefined: bit14 is ignored and `parity_err` is tied to 0.

## Structure
- Package `tli4970_pkg`:
  - frame bit positions (STATUS=15, PARITY=14, OCD=13, DATA_MSB=12)
  - FRAME_BITS=16
  - default OFFSET
  - FSM state enum
- Sub-module `spi_frame_rx`: a single-frame SPI read engine with a start/done handshake, generating SCK/CS-enable and shifting in 16 bits. The top level handles tick timing, channel sequencing, the MISO mux, decode and flags.

## Test plan
- NUM_CHANNELS=2, SPI_DIV=2. Sensor models return 0x1000 and 0x1FFF. Required: `current` = 0 and 4095, valid pulses 69 cycles apart, CS low exactly 66 cycles each.
- Frame 0x0000 on ch0 → `current[0]` = −4096. Frame 0x2000 → `current[0]` = −4096 with `ocd[0]`=1.
- Frame 0x8123 on ch1 → `status_seen[1]`=1, `current[1]` unchanged, no pulse. Pulse `err_clear` → flag returns to 0.
- With `TLI4970_PARITY_EN`: frame 0x4001 (even) is accepted with current −4095. Frame 0x0001 (odd) → `parity_err[0]`=1 and `current` is held.
- PERIOD smaller than the poll length → `overrun`=1 and polls never overlap. Assert `reset` mid-SHIFT → CS all high and SCK low the next cycle, outputs zeroed.
